// File: rtl/lvg_issuer_pkg.sv
// Shared definitions for the lvg command issuer: opcodes, instr field layout,
// issuer state encoding and a saturating counter helper.
package lvg_issuer_pkg;

    localparam int OP_LSB   = 0;
    localparam int OP_MSB   = 7;
    localparam int ADDR_LSB = 8;
    localparam int ADDR_MSB = 15;
    localparam int INSTR_W  = 16;

    localparam logic [7:0] LVG_OP_NOP    = 8'd0;
    localparam logic [7:0] LVG_OP_LOADL  = 8'd1;
    localparam logic [7:0] LVG_OP_LOADR  = 8'd2;
    localparam logic [7:0] LVG_OP_MATMUL = 8'd3;

    // Wide enough for any MATMUL window up to 32 cycles.
    localparam int MM_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONE  = 2'd1,
        S_MM   = 2'd2,
        S_GAP  = 2'd3
    } issuer_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/lvg_cmd_fifo.sv
// DEPTH x WIDTH synchronous command FIFO with show-ahead read data,
// full/empty flags and asynchronous active-low pointer reset.
module lvg_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: storage is deliberately not reset; empty/full come from the pointers,
    // so stale entries are never observed and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/lvg_issuer.sv
// Host-side command issuer for lvg: FIFO-buffered commands expanded into per-cycle instr words.
// Optional per-opcode issue counters are enabled by defining LVG_ISSUER_STATS_EN.
module lvg_issuer
    import lvg_issuer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MM_CYCLES = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [7:0]          cmd_op,
    input  logic [7:0]          cmd_addr,
    output logic [INSTR_W-1:0]  instr,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef LVG_ISSUER_STATS_EN
    ,
    output logic [15:0]         mm_count,
    output logic [15:0]         load_count
`endif
);

    localparam logic [MM_CNT_W-1:0] MM_LOAD = MM_CNT_W'(MM_CYCLES - 1);

    issuer_state_t        state;
    logic [MM_CNT_W-1:0]  mm_cnt;
    logic [INSTR_W-1:0]   head;
    logic [7:0]           head_op;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;

    lvg_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data ({cmd_addr, cmd_op}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_op   = head[OP_MSB:OP_LSB];
    assign cmd_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;
    // The MATMUL window never pops; every other state may start the next command.
    assign pop       = !fifo_empty && (state != S_MM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            mm_cnt <= '0;
            instr  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE, S_ONE, S_GAP: begin
                    if (pop) begin
                        if (head_op == LVG_OP_MATMUL) begin
                            state  <= S_MM;
                            instr  <= head;
                            mm_cnt <= MM_LOAD;
                        end else if (head_op > LVG_OP_MATMUL) begin
                            state <= S_ONE;
                            instr <= '0;
                            err   <= 1'b1;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ONE;
                            instr <= head;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                        instr <= '0;
                    end
                end
                S_MM: begin
                    // The mandatory zero cycle lets lvg see a fresh MATMUL edge next time.
                    if (mm_cnt == '0) begin
                        state <= S_GAP;
                        instr <= '0;
                        done  <= 1'b1;
                    end else begin
                        mm_cnt <= mm_cnt - MM_CNT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef LVG_ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mm_count   <= '0;
            load_count <= '0;
        end else if (pop) begin
            if (head_op == LVG_OP_MATMUL) begin
                mm_count <= sat_inc16(mm_count);
            end
            if (head_op == LVG_OP_LOADL || head_op == LVG_OP_LOADR) begin
                load_count <= sat_inc16(load_count);
            end
        end
    end
`endif

endmodule
